path_delay_prober: RTL and testbench
====================================

Name: path_delay_prober

Overview:
- Launch/capture controller at the driving and observing end of a combinational path under test, such as an ISCAS-style delay chain that may contain a Trojan trigger/payload.
- Toggles the path input, samples the path output through a 2-flop synchronizer and counts clock edges until the expected transition arrives.
- Repeats over N trials and records last/min/max/sum delay.
- Raises an alarm when any delay exceeds a golden threshold or a transition never arrives. This is the measurement side of the hardware-delay Trojan detection flow.

Parameters:
- CW, 8, width of the delay counter and of delay_last/min/max.
- TIMEOUT, 200, edge count at which a trial is abandoned (must be < 2^CW).
- SETTLE_CYC, 16, idle cycles before each launch (≥1).
- THRESH, 10, maximum acceptable delay; a larger delay raises the alarm.
- INVERT, 0, 1 if the path output is the logical inverse of its input.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_trials  in  8  trials per run; 0 is treated as 1; latched at start.
- stim_out  out  1  drives the path input.
- resp_in  in  1  path output; asynchronous to the launch, so it is synchronized.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a run.
- delay_last  out  CW  delay of the most recent trial.
- delay_min  out  CW  minimum over the run.
- delay_max  out  CW  maximum over the run.
- delay_sum  out  CW+8  sum over the run.
- timeout_err  out  1  sticky per run: some trial hit TIMEOUT.
- alarm  out  1  valid from done until the next start: (delay_max > THRESH) or timeout_err.

Behaviour:
- Reset, taken on any clk edge with rst=1 regardless of state:
  - state=IDLE; stim_out=0; busy=0; done=0; alarm=0; timeout_err=0.
  - delay_last=0; delay_min=all ones; delay_max=0; delay_sum=0; both synchronizer flops=INVERT.
- Synchronizer: s1<=resp_in; resp_s<=s1.
- Expected level exp = stim_out ^ INVERT.
- IDLE, start=1:
  - latch trials (0 becomes 1).
  - clear min to all ones, clear max/sum/timeout_err/alarm.
  - go to SETTLE, busy=1, settle counter=0.
- SETTLE: count SETTLE_CYC edges, then go to LAUNCH. stim_out is held.
- LAUNCH (one cycle): stim_out<=~stim_out; cnt<=0; go to WAIT. Successive trials therefore alternate rising and falling launches.
- WAIT, each edge: cnt<=cnt+1.
  - Let D = cnt+1. D counts edges from the launch edge, inclusive of the detecting edge.
  - If resp_s==exp (exp evaluated with the new stim_out), record D and go to REC.
  - Else if D==TIMEOUT, record TIMEOUT, set timeout_err, go to REC.
- Zero-delay loopback (resp_in wired directly to stim_out) yields D=2, which is the synchronizer latency.
- Recording (REC, one cycle):
  - delay_last<=D; delay_min<=min(min,D); delay_max<=max(max,D).
  - delay_sum<=sum+D; no overflow is possible for 255 trials at CW=8.
  - decrement remaining trials; if remaining was 1, go to FIN, else go to SETTLE.
- FIN (one cycle): done=1; alarm<=(delay_max>THRESH)|timeout_err; busy<=0; go to IDLE.
- Results hold until the next start. start during busy is ignored.
- Glitching response: the first edge where resp_s==exp terminates the trial. Later bounces are ignored because SETTLE precedes the next launch.
- A response already equal to exp at launch is impossible after a clean settle. A stuck path reads as timeout on alternate trials.
- Reset mid-run aborts with no done pulse and restores all outputs to their reset values.

Test Plan:
1. resp_in=stim_out direct, num_trials=4 -> after each trial delay_last=2; at done min=max=2, sum=8, timeout_err=0, alarm=0, stim_out back to 0.
2. Bench loopback through a 5-cycle delay line, INVERT=0, num_trials=3 -> delay_last=7 each trial, sum=21, alarm=0; with THRESH=6 -> alarm=1.
3. Loopback delays alternating 3 and 9 cycles on rise/fall, num_trials=2 -> min=5, max=11, sum=16, alarm=1 (11>10).
4. resp_in tied to 0, num_trials=2 -> trial 1 gives 200 with timeout_err=1; trial 2 (falling, exp=0) gives 2; at done max=200, alarm=1.
5. INVERT=1 with resp_in=~stim_out -> delay=2 per trial; the same stimulus with INVERT=0 -> every trial times out.
6. rst=1 mid-WAIT -> next edge: state IDLE, busy=0, stim_out=0, no done pulse. Also: num_trials=0 -> exactly one trial. start pulsed while busy -> no restart and counters unaffected.

Source files
------------

// File: rtl/path_delay_prober_if.sv
// path_delay_prober_if: run control, path stimulus/response and delay results of the prober
interface path_delay_prober_if #(parameter int CW = 8);
    logic          start;
    logic [7:0]    num_trials;
    logic          stim_out;
    logic          resp_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] delay_last;
    logic [CW-1:0] delay_min;
    logic [CW-1:0] delay_max;
    logic [CW+7:0] delay_sum;
    logic          timeout_err;
    logic          alarm;
    modport master (
        output start, num_trials, resp_in,
        input  stim_out, busy, done, delay_last, delay_min, delay_max, delay_sum, timeout_err, alarm
    );
    modport slave (
        input  start, num_trials, resp_in,
        output stim_out, busy, done, delay_last, delay_min, delay_max, delay_sum, timeout_err, alarm
    );
endinterface

// File: rtl/path_delay_prober.sv
// path_delay_prober: launches transitions into a path under test and measures edges until the response arrives
module path_delay_prober #(
    parameter int CW         = 8,
    parameter int TIMEOUT    = 200,
    parameter int SETTLE_CYC = 16,
    parameter int THRESH     = 10,
    parameter bit INVERT     = 1'b0
) (
    input logic clk,
    input logic rst,
    path_delay_prober_if.slave p
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, REC, FIN} state_t;
    state_t        state, state_nx;
    logic          s1, resp_s;
    logic [CW-1:0] cnt, d_nx, max_nx;
    logic [SW-1:0] scnt;
    logic [7:0]    left;
    logic          hit, to_hit, settle_end;
    assign d_nx       = cnt + 1'b1;
    assign hit        = (resp_s == (p.stim_out ^ INVERT)) && (cnt != '0);
    assign to_hit     = d_nx == CW'(TIMEOUT);
    assign settle_end = scnt == SW'(SETTLE_CYC - 1);
    assign max_nx     = (cnt > p.delay_max) ? cnt : p.delay_max;
    assign p.done     = state == FIN;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // next-state: the first WAIT sample predates the launch, so only D>=2 can terminate a trial
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = p.start ? SETTLE : IDLE;
            SETTLE:  state_nx = settle_end ? LAUNCH : SETTLE;
            LAUNCH:  state_nx = WAIT;
            WAIT:    state_nx = (hit || to_hit) ? REC : WAIT;
            REC:     state_nx = (left == 8'd1) ? FIN : SETTLE;
            default: state_nx = IDLE;
        endcase
    end
    // synchronizer, launch toggle, edge counting and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= INVERT;
            resp_s        <= INVERT;
            p.stim_out    <= 1'b0;
            p.busy        <= 1'b0;
            p.alarm       <= 1'b0;
            p.timeout_err <= 1'b0;
            p.delay_last  <= '0;
            p.delay_min   <= '1;
            p.delay_max   <= '0;
            p.delay_sum   <= '0;
            cnt           <= '0;
            scnt          <= '0;
            left          <= '0;
        end else begin
            s1     <= p.resp_in;
            resp_s <= s1;
            case (state)
                IDLE: if (p.start) begin
                    left          <= (p.num_trials == 8'd0) ? 8'd1 : p.num_trials;
                    p.delay_min   <= '1;
                    p.delay_max   <= '0;
                    p.delay_sum   <= '0;
                    p.timeout_err <= 1'b0;
                    p.alarm       <= 1'b0;
                    p.busy        <= 1'b1;
                    scnt          <= '0;
                end
                SETTLE: begin
                    scnt <= scnt + 1'b1;
                    if (settle_end) begin
                        p.stim_out <= ~p.stim_out;
                        cnt        <= '0;
                    end
                end
                WAIT: begin
                    cnt <= d_nx;
                    if (to_hit && !hit) p.timeout_err <= 1'b1;
                end
                REC: begin
                    p.delay_last <= cnt;
                    p.delay_min  <= (cnt < p.delay_min) ? cnt : p.delay_min;
                    p.delay_max  <= max_nx;
                    p.delay_sum  <= p.delay_sum + {8'd0, cnt};
                    left         <= left - 1'b1;
                    scnt         <= '0;
                    if (left == 8'd1) p.alarm <= (max_nx > CW'(THRESH)) || p.timeout_err;
                end
                FIN: p.busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_path_delay_prober.sv
// tb_path_delay_prober: table-driven runs of three prober variants against a modelled delay path
module tb_path_delay_prober;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    path_delay_prober_if #(.CW(8)) if0();
    path_delay_prober_if #(.CW(8)) if1();
    path_delay_prober_if #(.CW(8)) if2();

    path_delay_prober u0 (.clk(clk), .rst(rst), .p(if0.slave));
    path_delay_prober #(.THRESH(6)) u1 (.clk(clk), .rst(rst), .p(if1.slave));
    path_delay_prober #(.INVERT(1'b1)) u2 (.clk(clk), .rst(rst), .p(if2.slave));

    logic        start_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0]  ntr = 8'd1;
    logic [2:0]  stim, done, busy, tout, alm;
    logic [7:0]  last [3], mn [3], mx [3];
    logic [15:0] sm [3];
    logic [2:0]  rv;
    logic [15:0] hist [3] = '{16'd0, 16'd0, 16'd0};
    logic [3:0]  dr [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0]  df [3] = '{4'd0, 4'd0, 4'd0};
    logic        inv [3] = '{1'b0, 1'b0, 1'b0};
    logic        se [3] = '{1'b0, 1'b0, 1'b0};
    logic        sv [3] = '{1'b0, 1'b0, 1'b0};

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.num_trials = ntr;
    assign if1.num_trials = ntr;
    assign if2.num_trials = ntr;
    assign if0.resp_in = rv[0];
    assign if1.resp_in = rv[1];
    assign if2.resp_in = rv[2];
    assign stim = {if2.stim_out, if1.stim_out, if0.stim_out};
    assign done = {if2.done, if1.done, if0.done};
    assign busy = {if2.busy, if1.busy, if0.busy};
    assign tout = {if2.timeout_err, if1.timeout_err, if0.timeout_err};
    assign alm  = {if2.alarm, if1.alarm, if0.alarm};
    assign last[0] = if0.delay_last; assign last[1] = if1.delay_last; assign last[2] = if2.delay_last;
    assign mn[0] = if0.delay_min; assign mn[1] = if1.delay_min; assign mn[2] = if2.delay_min;
    assign mx[0] = if0.delay_max; assign mx[1] = if1.delay_max; assign mx[2] = if2.delay_max;
    assign sm[0] = if0.delay_sum; assign sm[1] = if1.delay_sum; assign sm[2] = if2.delay_sum;

    // path model: per-direction registered delay line (0 = wire), optional inversion or stuck level
    always @(posedge clk)
        for (int k = 0; k < 3; k++) hist[k] <= {hist[k][14:0], stim[k]};
    for (genvar g = 0; g < 3; g++) begin : g_path
        logic [3:0] dsel;
        assign dsel  = stim[g] ? dr[g] : df[g];
        assign rv[g] = se[g] ? sv[g] : (((dsel == 4'd0) ? stim[g] : hist[g][dsel - 4'd1]) ^ inv[g]);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input int k, input int n);
        @(negedge clk);
        ntr = 8'(n);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int c = 0;
        while (!done[k] && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", {31'd0, done[k]}, 32'd1);
    endtask

    typedef struct {
        int k; int n; logic [3:0] dr; logic [3:0] df; bit inv; bit se; bit sv;
        int last; int mn; int mx; int sm; bit to; bit al; bit st;
    } vec_t;
    vec_t tv [8];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{0, 4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,   2,   2,   2,   8, 1'b0, 1'b0, 1'b0};
        tv[1] = '{0, 2, 4'd3, 4'd9, 1'b0, 1'b0, 1'b0,  11,   5,  11,  16, 1'b0, 1'b1, 1'b0};
        tv[2] = '{0, 2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0,   2,   2, 200, 202, 1'b1, 1'b1, 1'b0};
        tv[3] = '{0, 2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 200, 200, 200, 400, 1'b1, 1'b1, 1'b0};
        tv[4] = '{0, 0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,   2,   2,   2,   2, 1'b0, 1'b0, 1'b1};
        tv[5] = '{0, 3, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0,   7,   7,   7,  21, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1, 3, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0,   7,   7,   7,  21, 1'b0, 1'b1, 1'b1};
        tv[7] = '{2, 2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,   2,   2,   2,   4, 1'b0, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stim", {29'd0, stim}, 32'd0);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        chk("rst_done", {29'd0, done}, 32'd0);
        chk("rst_alarm", {29'd0, alm}, 32'd0);
        chk("rst_to", {29'd0, tout}, 32'd0);
        chk("rst_last", {24'd0, last[0]}, 32'd0);
        chk("rst_min", {24'd0, mn[0]}, 32'd255);
        chk("rst_max", {24'd0, mx[0]}, 32'd0);
        chk("rst_sum", {16'd0, sm[0]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = tv[i];
            dr[v.k] = v.dr; df[v.k] = v.df; inv[v.k] = v.inv; se[v.k] = v.se; sv[v.k] = v.sv;
            pulse_start(v.k, v.n);
            chk($sformatf("v%0d_busy", i), {31'd0, busy[v.k]}, 32'd1);
            wait_done(v.k);
            chk($sformatf("v%0d_last", i), {24'd0, last[v.k]}, v.last);
            chk($sformatf("v%0d_min", i), {24'd0, mn[v.k]}, v.mn);
            chk($sformatf("v%0d_max", i), {24'd0, mx[v.k]}, v.mx);
            chk($sformatf("v%0d_sum", i), {16'd0, sm[v.k]}, v.sm);
            chk($sformatf("v%0d_to", i), {31'd0, tout[v.k]}, {31'd0, v.to});
            chk($sformatf("v%0d_alarm", i), {31'd0, alm[v.k]}, {31'd0, v.al});
            chk($sformatf("v%0d_stim", i), {31'd0, stim[v.k]}, {31'd0, v.st});
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), {31'd0, busy[v.k]}, 32'd0);
        end
        dr[0] = 4'd0; df[0] = 4'd0; inv[0] = 1'b0; se[0] = 1'b0;
        pulse_start(0, 2);
        repeat (10) @(negedge clk);
        pulse_start(0, 5);
        wait_done(0);
        chk("busy_start_sum", {16'd0, sm[0]}, 32'd4);
        chk("busy_start_max", {24'd0, mx[0]}, 32'd2);
        chk("busy_start_stim", {31'd0, stim[0]}, 32'd0);
        dr[0] = 4'd12; df[0] = 4'd12;
        pulse_start(0, 1);
        repeat (24) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
        chk("pre_rst_stim", {31'd0, stim[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("mid_rst_stim", {31'd0, stim[0]}, 32'd0);
        chk("mid_rst_last", {24'd0, last[0]}, 32'd0);
        chk("mid_rst_min", {24'd0, mn[0]}, 32'd255);
        chk("mid_rst_sum", {16'd0, sm[0]}, 32'd0);
        begin
            logic seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                seen = seen | done[0] | busy[0];
            end
            chk("mid_rst_no_done", {31'd0, seen}, 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
